// File: rtl/kyber_pkg.sv
`default_nettype none
// kyber_pkg: shared Kyber arithmetic constants, coefficient types and helpers.
// Revision 1.0
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int QINV    = 62209;
  localparam int MONT    = 2285;
  localparam int MONT_R2 = 1353;
  localparam int WID     = 16;
  localparam int MWID    = 32;

  typedef logic signed [WID-1:0]  coef_t;
  typedef logic signed [MWID-1:0] prod_t;

  // Maps a value in (-q, q) onto the canonical range [0, q-1].
  function automatic logic [WID-1:0] canon_q(input coef_t t);
    coef_t q_c;
    q_c = coef_t'(KYBER_Q);
    return t[WID-1] ? WID'(t + q_c) : WID'(t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_redc_pipe.sv
`default_nettype none
// mont_redc_pipe: two-stage signed Montgomery reduction, returns p * 2^-16 mod q in (-q, q).
// Revision 1.0
module mont_redc_pipe
  import kyber_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  in_valid,
  input  logic  in_last,
  input  prod_t in_data,
  output logic  out_valid,
  output logic  out_last,
  output coef_t out_data
);

  localparam logic [WID-1:0] QINV_W = WID'(QINV);
  localparam prod_t          Q_P    = prod_t'(KYBER_Q);

  logic [WID-1:0] u_lo;
  logic           a_valid;
  logic           a_last;
  prod_t          a_p;
  coef_t          a_u;
  prod_t          diff;

  // Only the low half of the product matters for u, so a 16x16 multiply suffices.
  assign u_lo = in_data[WID-1:0] * QINV_W;

  // The low 16 bits of diff are zero by construction; the high half is the result.
  assign diff = a_p - prod_t'(a_u) * Q_P;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_last    <= 1'b0;
      a_p       <= '0;
      a_u       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      a_valid   <= in_valid;
      a_last    <= in_valid & in_last;
      out_valid <= a_valid;
      out_last  <= a_valid & a_last;
      if (in_valid) begin
        a_p <= in_data;
        a_u <= u_lo;
      end
      if (a_valid) begin
        out_data <= diff[MWID-1:WID];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/montgomery_encode.sv
`default_nettype none
// montgomery_encode: streaming converter a -> a*2^16 mod q in [0, q-1], 4-stage valid/ready pipeline.
// Revision 1.0
module montgomery_encode
  import kyber_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [WID-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic        [WID-1:0] out_data,
  output logic                  out_last
);

  localparam prod_t R2_P = prod_t'(MONT_R2);

  logic  advance;
  logic  s1_valid;
  logic  s1_last;
  prod_t s1_p;
  logic  red_valid;
  logic  red_last;
  coef_t red_t;

  // The whole pipeline moves in lockstep; bubbles are held, never squeezed out.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        s1_p <= prod_t'(in_data) * R2_P;
      end
    end
  end

  mont_redc_pipe u_redc (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (s1_valid),
    .in_last   (s1_last),
    .in_data   (s1_p),
    .out_valid (red_valid),
    .out_last  (red_last),
    .out_data  (red_t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= red_valid;
      out_last  <= red_valid & red_last;
      if (red_valid) begin
        out_data <= canon_q(red_t);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_encode.sv
`default_nettype none
// tb_montgomery_encode: randomized scoreboard bench for montgomery_encode against a*65536 mod q.
// Revision 1.0
module tb_montgomery_encode;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          c;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  montgomery_encode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: a * 2^16 reduced mod q into [0, q-1].
  function automatic logic [15:0] ref_mont(input int a);
    longint m;
    m = (longint'(a) * 65536) % 3329;
    if (m < 0) m += 3329;
    return 16'(m);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 99) < 65);
    endcase
  end

  // Monitor: samples both handshakes on the falling edge and scores outputs.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) check("range_lt_q", (out_data < 16'd3329), 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", out_data, e.d);
          check("last", out_last, e.l);
          if (lat_chk) check("latency", cyc - e.c, 4);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{d: ref_mont(int'($signed(in_data))), l: in_last, c: cyc});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic send(input logic [15:0] a, input logic l, output int tries);
    bit acc;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = a;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          nacc;
    logic [15:0] frozen;
    logic [15:0] dirs[3];
    logic [15:0] ext[3];

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single coefficients with exact latency.
    lat_chk = 1'b1;
    dirs[0] = 16'd0;
    dirs[1] = 16'd1;
    dirs[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      send(dirs[i], 1'b0, t);
      drain();
    end

    // Extremes back-to-back; each must be accepted on the first try.
    ext[0] = 16'h7FFF;
    ext[1] = 16'h8000;
    ext[2] = 16'd3328;
    for (int i = 0; i < 3; i++) begin
      send(ext[i], 1'b0, t);
      check("b2b_first_try", t, 1);
    end
    drain();

    // 256-coefficient polynomial with random back-pressure.
    lat_chk  = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 256; i++) begin
      send(16'(i), (i == 255), t);
    end
    rdy_mode = 0;
    drain();

    // Fill the pipeline against a stalled sink.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    nacc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'($urandom);
      @(negedge clk);
      if (in_ready) nacc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_accepted", nacc, 4);
    check("stall_sb_depth", sb.size(), 4);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    frozen = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_frozen", out_data, frozen);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    // Reset with three coefficients in flight.
    lat_chk = 1'b1;
    send(16'd100, 1'b0, t);
    send(16'd200, 1'b1, t);
    send(16'd300, 1'b0, t);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'd1, 1'b0, t);
    drain();

    // Long random run with bubbles and stalls.
    lat_chk  = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      case ($urandom_range(0, 19))
        0:       send(16'h7FFF, 1'($urandom), t);
        1:       send(16'h8000, 1'($urandom), t);
        default: send(16'($urandom), 1'($urandom), t);
      endcase
    end
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
